gate_and_dmux_slice: RTL and testbench

- Gate-level logic slice for the CPU's basic-logic layer.
- Bundles three functions: a 1-bit AND, a 16-bit bitwise AND, and a 1-to-2 demultiplexer.
- Each function has a combinational output (zero latency) and a registered copy, so downstream pipeline stages can take either.
- All gating is built from NAND primitives, matching the rest of the logic layer.

---
 rtl/gate_and_dmux_slice_pkg.sv | 15 +
 rtl/gate_and_dmux_slice_if.sv | 35 +++
 rtl/gate_and_dmux_slice_cell.sv | 15 +
 rtl/gate_and_dmux_slice.sv | 69 ++++++
 tb/tb_gate_and_dmux_slice.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/gate_and_dmux_slice_pkg.sv
// Shared constants, types and the NAND primitive used by the basic-logic layer.
package logic_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  localparam word_t WORD_ZERO = '0;

  // Two-input NAND: the only gating primitive this layer builds from.
  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

endpackage

// File: rtl/gate_and_dmux_slice_if.sv
// Operand/result bundle for the AND and demux slice.
interface gate_and_dmux_slice_if #(
  parameter int WIDTH = 16
);

  logic             a;
  logic             b;
  logic [WIDTH-1:0] a16;
  logic [WIDTH-1:0] b16;
  logic             in;
  logic             sel;
  logic             y_and;
  logic [WIDTH-1:0] y16_and;
  logic             a_out;
  logic             b_out;
  logic             y_and_q;
  logic [WIDTH-1:0] y16_and_q;
  logic             a_out_q;
  logic             b_out_q;

  // Driver side: supplies operands, observes results.
  modport master (
    output a, b, a16, b16, in, sel,
    input  y_and, y16_and, a_out, b_out,
    input  y_and_q, y16_and_q, a_out_q, b_out_q
  );

  // Slice side: consumes operands, produces results.
  modport slave (
    input  a, b, a16, b16, in, sel,
    output y_and, y16_and, a_out, b_out,
    output y_and_q, y16_and_q, a_out_q, b_out_q
  );

endinterface

// File: rtl/gate_and_dmux_slice_cell.sv
// 1-bit AND cell: NAND followed by a NAND wired as an inverter.
module nand_and_cell
  import logic_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y
);

  logic n;

  assign n = nand2(a, b);
  assign y = nand2(n, n);

endmodule

// File: rtl/gate_and_dmux_slice.sv
// Scalar AND, bus AND and 1:2 demux, each with a combinational output and
// a one-cycle registered copy.
module gate_and_dmux_slice
  import logic_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_and_dmux_slice_if.slave  bus
);

  logic             y_and;
  logic [WIDTH-1:0] y16_and;
  logic             a_out;
  logic             b_out;
  logic             sel_n;

  logic             y_and_d,   y_and_q;
  logic [WIDTH-1:0] y16_and_d, y16_and_q;
  logic             a_out_d,   a_out_q;
  logic             b_out_d,   b_out_q;

  nand_and_cell u_and (.a(bus.a), .b(bus.b), .y(y_and));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand_and_cell u_and16 (.a(bus.a16[i]), .b(bus.b16[i]), .y(y16_and[i]));
  end

  // Demux: each leg is the data gated by its own select polarity, so the
  // two outputs can never be high together.
  assign sel_n = nand2(bus.sel, bus.sel);

  nand_and_cell u_dmux_a (.a(bus.in), .b(sel_n),   .y(a_out));
  nand_and_cell u_dmux_b (.a(bus.in), .b(bus.sel), .y(b_out));

  // Next register state is simply the current combinational result.
  always_comb begin
    y_and_d   = y_and;
    y16_and_d = y16_and;
    a_out_d   = a_out;
    b_out_d   = b_out;
  end

  // Output registers; reset clears them without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_and_q   <= 1'b0;
      y16_and_q <= WIDTH'(WORD_ZERO);
      a_out_q   <= 1'b0;
      b_out_q   <= 1'b0;
    end else begin
      y_and_q   <= y_and_d;
      y16_and_q <= y16_and_d;
      a_out_q   <= a_out_d;
      b_out_q   <= b_out_d;
    end
  end

  assign bus.y_and     = y_and;
  assign bus.y16_and   = y16_and;
  assign bus.a_out     = a_out;
  assign bus.b_out     = b_out;
  assign bus.y_and_q   = y_and_q;
  assign bus.y16_and_q = y16_and_q;
  assign bus.a_out_q   = a_out_q;
  assign bus.b_out_q   = b_out_q;

endmodule

// File: tb/tb_gate_and_dmux_slice.sv
// Directed bench for gate_and_dmux_slice.
module tb_gate_and_dmux_slice;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  gate_and_dmux_slice_if #(.WIDTH(W)) bus ();

  gate_and_dmux_slice #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [W-1:0] e16,
                         input logic ey, input logic ea, input logic eb);
    check({tag, " y16_and_q"}, bus.y16_and_q, e16);
    check({tag, " y_and_q"},   W'(bus.y_and_q), W'(ey));
    check({tag, " a_out_q"},   W'(bus.a_out_q), W'(ea));
    check({tag, " b_out_q"},   W'(bus.b_out_q), W'(eb));
  endtask

  logic [W-1:0] ops [18];
  logic [W-1:0] ra, rb;
  logic         exp_y [4];
  logic [1:0]   exp_dm [4];

  initial begin
    checks = 0;
    errors = 0;
    ops = '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h00FF,
            16'hFF00, 16'h0F0F, 16'hF0F0, 16'h3333, 16'hCCCC, 16'hAAAA,
            16'h5555, 16'h1234, 16'hFEDC, 16'h00F0, 16'h0F00, 16'h1357};
    exp_y  = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_dm = '{2'b00, 2'b10, 2'b00, 2'b01};

    rst_n   = 1'b0;
    bus.a   = 1'b0;
    bus.b   = 1'b0;
    bus.a16 = '0;
    bus.b16 = '0;
    bus.in  = 1'b0;
    bus.sel = 1'b0;
    #1;
    check_q("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Combinational paths work while reset is held.
    for (int i = 0; i < 4; i++) begin
      {bus.a, bus.b} = 2'(i);
      #1;
      check($sformatf("y_and ab=%0d", i), W'(bus.y_and), W'(exp_y[i]));
    end

    for (int i = 0; i < 4; i++) begin
      {bus.sel, bus.in} = 2'(i);
      #1;
      check($sformatf("demux sel_in=%0d", i), W'({bus.a_out, bus.b_out}),
            W'(exp_dm[i]));
    end

    check("spot FFFF&1234", 16'hFFFF & 16'h1234, 16'h1234);
    bus.a16 = 16'hAAAA; bus.b16 = 16'h5555; #1;
    check("AAAA&5555", bus.y16_and, 16'h0000);
    bus.a16 = 16'hF0F0; bus.b16 = 16'h3333; #1;
    check("F0F0&3333", bus.y16_and, 16'h3030);

    for (int i = 0; i < 18; i++) begin
      for (int j = 0; j < 18; j++) begin
        bus.a16 = ops[i];
        bus.b16 = ops[j];
        #1;
        check($sformatf("cross %h&%h", ops[i], ops[j]), bus.y16_and,
              ops[i] & ops[j]);
      end
    end

    for (int k = 0; k < 1000; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      bus.a16 = ra;
      bus.b16 = rb;
      #1;
      check($sformatf("rand %h&%h", ra, rb), bus.y16_and, ra & rb);
    end

    // Registers stayed cleared throughout, despite free-running clock.
    check_q("held in reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Release reset between edges, then apply the latency vector.
    @(negedge clk);
    rst_n   = 1'b1;
    bus.a16 = 16'hFFFF;
    bus.b16 = 16'h0F0F;
    bus.a   = 1'b1;
    bus.b   = 1'b1;
    bus.sel = 1'b1;
    bus.in  = 1'b1;
    #1;
    check_q("pre-edge", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_q("latency", 16'h0F0F, 1'b1, 1'b0, 1'b1);

    // Input change between edges must not reach the registers early.
    @(negedge clk);
    bus.sel = 1'b0;
    bus.b16 = 16'h00FF;
    #1;
    check_q("mid-cycle hold", 16'h0F0F, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_q("reload", 16'h00FF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus.sel = 1'b1;
    bus.b16 = 16'h0F0F;
    @(posedge clk);
    #1;
    check_q("restore", 16'h0F0F, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_q("async rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rst comb y16", bus.y16_and, 16'h0F0F);
    check("rst comb y",   W'(bus.y_and), W'(1'b1));
    check("rst comb dmx", W'({bus.a_out, bus.b_out}), W'(2'b01));
    @(posedge clk);
    #1;
    check_q("rst over edge", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_q("post-rst pre-edge", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_q("post-rst reload", 16'h0F0F, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
